// File: rtl/tdc_ctrl_if.sv
// rtl/tdc_ctrl_if.sv - control, sample and result signals between the sequencer and its user
interface tdc_ctrl_if #(
  parameter int NTDC = 64,
  parameter int PW   = 7
);
  logic            enable;
  logic            cal_start;
  logic [NTDC-1:0] sampled_tdc;
  logic [PW-1:0]   phase;
  logic            phase_valid;
  logic            no_edge;
  logic [PW-1:0]   period_est;
  logic            cal_done;
  logic            cal_err;

  // User side: drives control and TDC samples, observes decoded results
  modport master (
    output enable, cal_start, sampled_tdc,
    input  phase, phase_valid, no_edge, period_est, cal_done, cal_err
  );

  // Sequencer side
  modport slave (
    input  enable, cal_start, sampled_tdc,
    output phase, phase_valid, no_edge, period_est, cal_done, cal_err
  );
endinterface

// File: rtl/tdc_ctrl.sv
// rtl/tdc_ctrl.sv - delay-line TDC capture, edge decode, period calibration and phase streaming
module tdc_ctrl #(
  parameter int NTDC        = 64,
  parameter int PW          = 7,
  parameter int SETTLE_CYC  = 4,
  parameter int CAL_LOG2    = 4,
  parameter int CAL_TIMEOUT = 256
) (
  input logic        ref_clk,
  input logic        rst_n,
  tdc_ctrl_if.slave  bus
);

  localparam int ACC_W = PW + CAL_LOG2;
  localparam int N_W   = CAL_LOG2 + 1;
  localparam int ST_W  = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W = $clog2(CAL_TIMEOUT + 1);

  localparam logic [N_W-1:0]   N_TARGET   = N_W'(1 << CAL_LOG2);
  localparam logic [TMO_W-1:0] TMO_TARGET = TMO_W'(CAL_TIMEOUT);
  localparam logic [ST_W-1:0]  ST_LAST    = ST_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAL, RUN} state_t;

  state_t           state;
  logic [NTDC-1:0]  s1;
  logic [ST_W-1:0]  settle_cnt;
  logic [ACC_W-1:0] acc;
  logic [N_W-1:0]   n_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic [PW-1:0]    phase_q;
  logic             phase_valid_q;
  logic             no_edge_q;
  logic [PW-1:0]    period_q;
  logic             cal_done_q;
  logic             cal_err_q;

  logic [PW-1:0]    rise;
  logic [PW-1:0]    fall;
  logic             rise_found;
  logic             fall_found;
  logic             both_found;
  logic [PW-1:0]    diff;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   acc_dbl;
  logic [N_W-1:0]   n_inc;
  logic [TMO_W-1:0] tmo_inc;

  // Capture stage: taps are still settling after the edge, so only the registered copy is decoded
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) s1 <= '0;
    else        s1 <= bus.sampled_tdc;
  end

  // Edge decode: scan downward so the lowest-index transition of each kind wins (bubbles ignored)
  always_comb begin
    rise       = '0;
    fall       = '0;
    rise_found = 1'b0;
    fall_found = 1'b0;
    for (int k = NTDC - 1; k >= 1; k--) begin
      if (!s1[k-1] && s1[k]) begin
        rise       = PW'(k);
        rise_found = 1'b1;
      end
      if (s1[k-1] && !s1[k]) begin
        fall       = PW'(k);
        fall_found = 1'b1;
      end
    end
  end

  // Half-period measurement and accumulator/counter next values
  always_comb begin
    both_found = rise_found && fall_found;
    diff       = (rise >= fall) ? (rise - fall) : (fall - rise);
    acc_next   = acc + ACC_W'(diff);
    acc_dbl    = {acc_next, 1'b0};
    n_inc      = n_cnt + 1'b1;
    tmo_inc    = tmo_cnt + 1'b1;
  end

  // Sequencer: enable low always wins; all outputs are registered here
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      acc           <= '0;
      n_cnt         <= '0;
      tmo_cnt       <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      no_edge_q     <= 1'b0;
      period_q      <= '0;
      cal_done_q    <= 1'b0;
      cal_err_q     <= 1'b0;
    end else if (!bus.enable) begin
      state         <= IDLE;
      phase_valid_q <= 1'b0;
      cal_done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          phase_valid_q <= 1'b0;
          if (bus.cal_start) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            cal_err_q  <= 1'b0;
            cal_done_q <= 1'b0;
          end
        end
        SETTLE: begin
          phase_valid_q <= 1'b0;
          acc           <= '0;
          n_cnt         <= '0;
          tmo_cnt       <= '0;
          if (settle_cnt == ST_LAST) state <= CAL;
          else                       settle_cnt <= settle_cnt + 1'b1;
        end
        CAL: begin
          phase_valid_q <= 1'b0;
          tmo_cnt       <= tmo_inc;
          if (both_found) begin
            acc   <= acc_next;
            n_cnt <= n_inc;
          end
          // A sample that completes the average takes priority over a coincident timeout
          if (both_found && n_inc == N_TARGET) begin
            period_q   <= PW'(acc_dbl >> CAL_LOG2);
            cal_done_q <= 1'b1;
            state      <= RUN;
          end else if (tmo_inc == TMO_TARGET) begin
            cal_err_q  <= 1'b1;
            cal_done_q <= 1'b0;
            state      <= IDLE;
          end
        end
        RUN: begin
          phase_valid_q <= 1'b1;
          if (rise_found) begin
            phase_q   <= rise;
            no_edge_q <= 1'b0;
          end else begin
            no_edge_q <= 1'b1;
          end
          // Recalibration keeps the old period estimate until the new one is ready
          if (bus.cal_start) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            cal_done_q <= 1'b0;
            cal_err_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.no_edge     = no_edge_q;
  assign bus.period_est  = period_q;
  assign bus.cal_done    = cal_done_q;
  assign bus.cal_err     = cal_err_q;

endmodule

// File: tb/tb_tdc_ctrl.sv
// tb/tb_tdc_ctrl.sv - self-checking bench for tdc_ctrl
module tb_tdc_ctrl;

  logic clk;
  logic rst_n;

  tdc_ctrl_if #(.NTDC(64), .PW(7)) bus ();

  tdc_ctrl dut (
    .ref_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] word;
    logic [6:0]  ph;
    logic        ne;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word with taps lo..hi-1 high, everything else low
  function automatic logic [63:0] band(input int lo, input int hi);
    logic [63:0] w;
    w = '0;
    for (int k = lo; k < hi; k++) w[k] = 1'b1;
    return w;
  endfunction

  // Reference decode: edge masks by shifting, then lowest set bit
  function automatic void ref_decode(input logic [63:0] w, output bit rf, output int r,
                                     output bit ff, output int f);
    logic [63:0] re;
    logic [63:0] fe;
    re = w & ~(w << 1);
    fe = ~w & (w << 1);
    re[0] = 1'b0;
    fe[0] = 1'b0;
    rf = (re != 0);
    ff = (fe != 0);
    r = 0;
    f = 0;
    for (int k = 63; k >= 0; k--) begin
      if (re[k]) r = k;
      if (fe[k]) f = k;
    end
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    int lo, hi;
    case ($urandom_range(0, 6))
      0: w = '0;
      1: w = '1;
      2: w = {$urandom, $urandom};
      default: begin
        lo = $urandom_range(1, 62);
        hi = $urandom_range(lo + 1, 63);
        w  = band(lo, hi);
        if ($urandom_range(0, 1) == 1) w = ~w;
      end
    endcase
    return w;
  endfunction

  task automatic pulse_cal();
    bus.enable    = 1'b1;
    bus.cal_start = 1'b1;
    tick();
    bus.cal_start = 1'b0;
  endtask

  // Bounded wait for cal_done; returns cycles taken
  task automatic wait_done(input string name, input int budget, output int cyc);
    cyc = 0;
    while (bus.cal_done !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    if (bus.cal_done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: cal_done not seen within %0d cycles", name, budget);
    end
  endtask

  logic [63:0] nominal;
  logic [63:0] prev_w;
  logic [63:0] w;
  logic [6:0]  exp_ph;
  logic [6:0]  prev_ph;
  logic        exp_ne;
  bit          rf, ff;
  int          r, f, cyc, nvalid, sum;

  initial begin
    nominal = band(10, 30);
    tbl[0] = '{band(23, 41), 7'd23, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd23, 1'b1};
    tbl[2] = '{64'h0, 7'd23, 1'b1};
    tbl[3] = '{band(5, 6) | band(7, 64), 7'd5, 1'b0};
    tbl[4] = '{band(1, 64), 7'd1, 1'b0};
    tbl[5] = '{band(63, 64), 7'd63, 1'b0};
    tbl[6] = '{64'h1, 7'd63, 1'b1};

    rst_n           = 1'b0;
    bus.enable      = 1'b0;
    bus.cal_start   = 1'b0;
    bus.sampled_tdc = '0;
    repeat (3) tick();
    chk("reset_phase", 64'(bus.phase), 0);
    chk("reset_valid", 64'(bus.phase_valid), 0);
    chk("reset_no_edge", 64'(bus.no_edge), 0);
    chk("reset_period", 64'(bus.period_est), 0);
    chk("reset_cal_done", 64'(bus.cal_done), 0);
    chk("reset_cal_err", 64'(bus.cal_err), 0);
    #2 rst_n = 1'b1;

    // Nominal calibration: 4 settle + 16 cal cycles, period 2*20
    bus.sampled_tdc = nominal;
    bus.enable      = 1'b1;
    repeat (3) tick();
    chk("idle_enable_no_cal", 64'(bus.cal_done | bus.phase_valid), 0);
    pulse_cal();
    wait_done("nominal_cal", 400, cyc);
    chk("nominal_cal_latency", 64'(cyc), 20);
    chk("nominal_period", 64'(bus.period_est), 40);
    chk("nominal_cal_err", 64'(bus.cal_err), 0);
    repeat (2) tick();
    chk("run_valid", 64'(bus.phase_valid), 1);
    chk("run_phase_nominal", 64'(bus.phase), 10);

    // Table-driven decode in RUN, including the exact two-cycle latency
    prev_ph = 7'd10;
    for (int i = 0; i < 7; i++) begin
      bus.sampled_tdc = tbl[i].word;
      tick();
      chk($sformatf("tbl%0d_phase_1cyc", i), 64'(bus.phase), 64'(prev_ph));
      tick();
      chk($sformatf("tbl%0d_phase", i), 64'(bus.phase), 64'(tbl[i].ph));
      chk($sformatf("tbl%0d_no_edge", i), 64'(bus.no_edge), 64'(tbl[i].ne));
      chk($sformatf("tbl%0d_valid", i), 64'(bus.phase_valid), 1);
      prev_ph = tbl[i].ph;
    end

    // Random streaming in RUN against the reference decoder
    prev_w = tbl[6].word;
    exp_ph = tbl[6].ph;
    for (int i = 0; i < 200; i++) begin
      w = rand_word();
      bus.sampled_tdc = w;
      tick();
      ref_decode(prev_w, rf, r, ff, f);
      if (rf) begin
        exp_ph = 7'(r);
        exp_ne = 1'b0;
      end else begin
        exp_ne = 1'b1;
      end
      chk("rand_run_phase", 64'(bus.phase), 64'(exp_ph));
      chk("rand_run_no_edge", 64'(bus.no_edge), 64'(exp_ne));
      prev_w = w;
    end

    // Random recalibrations: zeros through settle, then random words
    for (int run = 0; run < 3; run++) begin
      bus.sampled_tdc = '0;
      tick();
      pulse_cal();
      chk("recal_done_cleared", 64'(bus.cal_done), 0);
      chk("recal_period_held", 64'(bus.period_est), 40);
      repeat (4) tick();
      nvalid = 0;
      sum    = 0;
      cyc    = 0;
      while (bus.cal_done !== 1'b1 && cyc < 250) begin
        w = rand_word();
        ref_decode(w, rf, r, ff, f);
        if (rf && ff && nvalid < 16) begin
          nvalid++;
          sum += (r > f) ? (r - f) : (f - r);
        end
        bus.sampled_tdc = w;
        tick();
        cyc++;
      end
      chk("rand_cal_done", 64'(bus.cal_done), 1);
      chk("rand_cal_period", 64'(bus.period_est), 64'(7'((2 * sum) >> 4)));
      bus.sampled_tdc = nominal;
      pulse_cal();
      wait_done("restore_cal", 400, cyc);
      chk("restore_period", 64'(bus.period_est), 40);
    end

    // Calibration timeout: all-zero words
    bus.sampled_tdc = '0;
    tick();
    pulse_cal();
    cyc = 0;
    while (bus.cal_err !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("timeout_latency", 64'(cyc), 260);
    chk("timeout_cal_err", 64'(bus.cal_err), 1);
    chk("timeout_cal_done", 64'(bus.cal_done), 0);
    chk("timeout_period_held", 64'(bus.period_est), 40);
    repeat (5) tick();
    chk("timeout_idle_valid", 64'(bus.phase_valid), 0);
    bus.sampled_tdc = nominal;
    pulse_cal();
    chk("cal_err_cleared", 64'(bus.cal_err), 0);
    wait_done("after_timeout_cal", 400, cyc);
    chk("after_timeout_period", 64'(bus.period_est), 40);

    // Abort mid-CAL with a word that would give a different period
    bus.sampled_tdc = band(10, 20);
    pulse_cal();
    repeat (9) tick();
    bus.enable = 1'b0;
    tick();
    chk("abort_valid", 64'(bus.phase_valid), 0);
    chk("abort_cal_done", 64'(bus.cal_done), 0);
    chk("abort_period", 64'(bus.period_est), 40);
    bus.enable = 1'b1;
    repeat (30) tick();
    chk("abort_stays_idle", 64'(bus.cal_done | bus.phase_valid), 0);
    chk("abort_period_kept", 64'(bus.period_est), 40);

    // Asynchronous reset mid-RUN
    bus.sampled_tdc = nominal;
    pulse_cal();
    wait_done("pre_reset_cal", 400, cyc);
    repeat (3) tick();
    chk("pre_reset_phase", 64'(bus.phase), 10);
    #3 rst_n = 1'b0;
    #1;
    chk("async_phase", 64'(bus.phase), 0);
    chk("async_valid", 64'(bus.phase_valid), 0);
    chk("async_no_edge", 64'(bus.no_edge), 0);
    chk("async_period", 64'(bus.period_est), 0);
    chk("async_cal_done", 64'(bus.cal_done), 0);
    chk("async_cal_err", 64'(bus.cal_err), 0);
    #2 rst_n = 1'b1;
    repeat (5) tick();
    chk("post_reset_idle", 64'(bus.phase_valid | bus.cal_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
